// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth HI/LO multiplier.
// Optional multiply-accumulate build: define BOOTH_MADD_EN.
package booth_pkg;
  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    WRITE = 2'd2
  } state_t;

  // {Q[0], q_1} recoding pairs
  localparam logic [1:0] PAIR_ADD = 2'b01;
  localparam logic [1:0] PAIR_SUB = 2'b10;
endpackage

// File: rtl/booth_seq_hilo_if.sv
// Request/result bus of the Booth HI/LO multiplier.
// madd exists only when BOOTH_MADD_EN is defined.
interface booth_seq_hilo_if
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             start;
  logic [WIDTH-1:0] in_m;
  logic [WIDTH-1:0] in_q;
  logic             mthi_we;
  logic             mtlo_we;
  logic [WIDTH-1:0] wdata;
`ifdef BOOTH_MADD_EN
  logic             madd;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, in_m, in_q, mthi_we, mtlo_we, wdata,
`ifdef BOOTH_MADD_EN
    output madd,
`endif
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, in_m, in_q, mthi_we, mtlo_we, wdata,
`ifdef BOOTH_MADD_EN
    input  madd,
`endif
    output busy, done, hi, lo
  );
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: add/subtract M by recoding pair, then
// arithmetic shift of {A,Q,q_1} right by one.
module booth_step
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_n,
  output logic [WIDTH-1:0] q_n,
  output logic             q1_n
);
  logic [WIDTH:0] m_ext;
  logic [WIDTH:0] sum;

  assign m_ext = {m[WIDTH-1], m};

  // Booth recoding: 01 adds M, 10 subtracts M, 00/11 pass A through
  always_comb begin
    sum = a;
    case ({q[0], q_1})
      PAIR_ADD: sum = a + m_ext;
      PAIR_SUB: sum = a - m_ext;
      default:  sum = a;
    endcase
  end

  assign a_n  = {sum[WIDTH], sum[WIDTH:1]};
  assign q_n  = {sum[0], q[WIDTH-1:1]};
  assign q1_n = q[0];
endmodule

// File: rtl/booth_seq_hilo.sv
// Multi-cycle signed Booth multiplier writing HI/LO, one step per clock.
// Define BOOTH_MADD_EN to accumulate the product into {hi,lo} on request.
module booth_seq_hilo
  import booth_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic              clk,
  input logic              rst_n,
  booth_seq_hilo_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [WIDTH:0]   a;      // one extra bit so -M of the most negative M fits
  logic [WIDTH-1:0] q;
  logic             q_1;
  logic [WIDTH-1:0] m;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic             busy_r, done_r;
`ifdef BOOTH_MADD_EN
  logic             madd_r;
`endif

  logic [WIDTH:0]     a_n;
  logic [WIDTH-1:0]   q_n;
  logic               q1_n;
  logic [2*WIDTH-1:0] prod;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .a(a), .q(q), .q_1(q_1), .m(m),
    .a_n(a_n), .q_n(q_n), .q1_n(q1_n)
  );

  assign prod = {a[WIDTH-1:0], q};

  // Control FSM plus datapath and architectural HI/LO registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a      <= '0;
      q      <= '0;
      q_1    <= 1'b0;
      m      <= '0;
      count  <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef BOOTH_MADD_EN
      madd_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // MTHI/MTLO land first; a same-cycle multiply overwrites later
          if (bus.mthi_we) hi_r <= bus.wdata;
          if (bus.mtlo_we) lo_r <= bus.wdata;
          if (bus.start) begin
            m      <= bus.in_m;
            q      <= bus.in_q;
            a      <= '0;
            q_1    <= 1'b0;
            count  <= CW'(WIDTH);
            busy_r <= 1'b1;
`ifdef BOOTH_MADD_EN
            madd_r <= bus.madd;
`endif
            state  <= RUN;
          end
        end
        RUN: begin
          a     <= a_n;
          q     <= q_n;
          q_1   <= q1_n;
          count <= count - CW'(1);
          if (count == CW'(1)) state <= WRITE;
        end
        WRITE: begin
`ifdef BOOTH_MADD_EN
          if (madd_r) {hi_r, lo_r} <= {hi_r, lo_r} + prod;
          else        {hi_r, lo_r} <= prod;
`else
          {hi_r, lo_r} <= prod;
`endif
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;
endmodule

// File: tb/tb_booth_seq_hilo.sv
// Self-checking bench for booth_seq_hilo (covers BOOTH_MADD_EN when defined).
module tb_booth_seq_hilo;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  booth_seq_hilo_if #(.WIDTH(W)) bus ();

  booth_seq_hilo #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_hilo = '0;   // reference HI:LO

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.start = 1'b0; bus.in_m = '0; bus.in_q = '0;
    bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0; bus.wdata = '0;
`ifdef BOOTH_MADD_EN
    bus.madd = 1'b0;
`endif
  endtask

  // MTHI/MTLO write in IDLE; entered and left at a falling edge
  task automatic mt(input logic hw, input logic lw, input logic [W-1:0] d);
    bus.mthi_we = hw; bus.mtlo_we = lw; bus.wdata = d;
    @(negedge clk);
    bus.mthi_we = 1'b0; bus.mtlo_we = 1'b0;
    if (hw) exp_hilo[2*W-1:W] = d;
    if (lw) exp_hilo[W-1:0]   = d;
    chk("mt_hilo", {bus.hi, bus.lo}, exp_hilo);
  endtask

  // Full multiply with optional same-cycle MTHI; checks latency and result
  task automatic do_mul(input logic [W-1:0] m, input logic [W-1:0] q,
                        input logic madd, input logic hw, input logic [W-1:0] d);
    int n, nb, p;
    logic eff_madd;
    eff_madd = 1'b0;
    bus.start = 1'b1; bus.in_m = m; bus.in_q = q;
    bus.mthi_we = hw; bus.wdata = d;
`ifdef BOOTH_MADD_EN
    bus.madd = madd;
    eff_madd = madd;
`endif
    @(negedge clk);
    bus.start = 1'b0; bus.mthi_we = 1'b0;
    chk("accept_busy_done", {14'd0, bus.busy, bus.done}, 16'b10);
    if (hw) begin
      exp_hilo[2*W-1:W] = d;
      chk("mthi_with_start", {8'd0, bus.hi}, {8'd0, d});
    end
    n = 0; nb = 0;
    while (!bus.done && n < 20) begin
      if (bus.busy) nb++;
      @(negedge clk);
      n++;
    end
    chk("done_latency", 16'(n), 16'(W + 1));
    chk("busy_cycles", 16'(nb), 16'(W + 1));
    chk("busy_at_done", {15'd0, bus.busy}, 16'd0);
    p = $signed(m) * $signed(q);
    if (eff_madd) exp_hilo = exp_hilo + 16'(p);
    else          exp_hilo = 16'(p);
    chk("product", {bus.hi, bus.lo}, exp_hilo);
  endtask

  initial begin
    int nd;
    logic [15:0] cap;
    clear_inputs();
    repeat (2) @(negedge clk);
    chk("reset_state", {bus.hi, bus.lo}, 16'h0000);
    chk("reset_busy_done", {14'd0, bus.busy, bus.done}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // directed products
    do_mul(8'd4, 8'd2, 1'b0, 1'b0, 8'h00);
    chk("4x2", {bus.hi, bus.lo}, 16'h0008);
    do_mul(8'hCE, 8'd50, 1'b0, 1'b0, 8'h00);   // back-to-back start right after done
    chk("-50x50", {bus.hi, bus.lo}, 16'hF63C);
    @(negedge clk);
    chk("done_pulse_width", {15'd0, bus.done}, 16'd0);
    do_mul(8'd30, 8'hC4, 1'b0, 1'b0, 8'h00);
    chk("30x-60", {bus.hi, bus.lo}, 16'hF8F8);
    do_mul(8'hFB, 8'd2, 1'b0, 1'b0, 8'h00);
    chk("-5x2", {bus.hi, bus.lo}, 16'hFFF6);
    do_mul(8'h80, 8'h80, 1'b0, 1'b0, 8'h00);
    chk("-128x-128", {bus.hi, bus.lo}, 16'h4000);
    do_mul(8'h80, 8'h7F, 1'b0, 1'b0, 8'h00);
    chk("-128x127", {bus.hi, bus.lo}, 16'hC080);
    do_mul(8'd6, 8'd7, 1'b0, 1'b1, 8'h33);     // MTHI with start: product wins
    chk("mthi_start_result", {bus.hi, bus.lo}, 16'h002A);

    // start and MTHI while busy are ignored
    bus.start = 1'b1; bus.in_m = 8'd7; bus.in_q = 8'hFD;
    @(negedge clk);                             // accepted at edge 0
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.start = 1'b1; bus.in_m = 8'd9; bus.in_q = 8'd9;
    @(negedge clk);                             // edge 3
    bus.start = 1'b0; bus.mthi_we = 1'b1; bus.wdata = 8'hAA;
    @(negedge clk);                             // edge 4
    bus.mthi_we = 1'b0;
    chk("mthi_ignored_busy", {8'd0, bus.hi}, {8'd0, exp_hilo[15:8]});
    nd = 0; cap = '0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin nd++; cap = {bus.hi, bus.lo}; end
      @(negedge clk);
    end
    chk("single_done", 16'(nd), 16'd1);
    chk("ignored_start_result", cap, 16'hFFEB);
    exp_hilo = 16'hFFEB;
    chk("hilo_after_idle", {bus.hi, bus.lo}, 16'hFFEB);

    // MTLO then reset during a multiply
    mt(1'b0, 1'b1, 8'h5A);
    chk("mtlo_5a", {8'd0, bus.lo}, 16'h005A);
    bus.start = 1'b1; bus.in_m = 8'd3; bus.in_q = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);                             // edge 5 samples reset
    rst_n = 1'b1;
    exp_hilo = '0;
    chk("rst_busy", {15'd0, bus.busy}, 16'd0);
    chk("rst_hilo", {bus.hi, bus.lo}, 16'h0000);
    nd = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) nd++;
      @(negedge clk);
    end
    chk("rst_no_done", 16'(nd), 16'd0);

`ifdef BOOTH_MADD_EN
    do_mul(8'd4, 8'd2, 1'b0, 1'b0, 8'h00);
    do_mul(8'd4, 8'd2, 1'b1, 1'b0, 8'h00);
    chk("madd_accum", {bus.hi, bus.lo}, 16'h0010);
    mt(1'b1, 1'b1, 8'hFF);
    do_mul(8'd1, 8'd1, 1'b1, 1'b0, 8'h00);
    chk("madd_wrap", {bus.hi, bus.lo}, 16'h0000);
`endif

    // randomized products against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0)
        mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      do_mul(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 8'($urandom));
    end

    @(negedge clk);
    chk("final_done_low", {15'd0, bus.done}, 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
